bnn_tile_engine: RTL and testbench
==================================

# bnn_tile_engine

Parametrised successor to the fixed 16-lane binary-neural-net datapath. It streams packed binary activation words and matching weight rows through an XNOR-popcount array of `LANES` accumulators. After a programmable number of words it scales each lane by `alpha+beta`, clips it with hard-tanh and binarises it into one packed output word. Unlike the fixed datapath, it has valid/ready handshakes on both sides, saturating accumulation and an explicit tile FSM. It also optionally derives `beta` from the previous tile's activation magnitude. It sits between the weight/activation memories and the activation write-back path.

## Interface
- `LANES`, 16, output neurons per tile (one accumulator each)
- `ACT_W`, 16, bits per activation/weight word
- `ACC_W`, 11, signed accumulator width
- `CLIP`, 127, hard-tanh bound (clip range is ±CLIP)
- `SUM_W`, 18, adaptive-beta magnitude sum width
- `clk` input 1: the block's single clock
- `rst_n` input 1: reset, asynchronous and active-low
- `start` input 1: begins a tile; only honoured in IDLE
- `num_words` input 8: words per tile, latched at start
- `alpha` input 3: per-tile shift, latched at start
- `beta_cfg` input 3: static beta
- `beta_adapt` input 1: 1 selects the adaptive beta
- `sum_shift` input 4: adaptive-beta window offset
- `in_valid` input 1: input beat valid
- `in_ready` output 1: input beat accepted when both `in_valid` and `in_ready` are high
- `act_in` input ACT_W: packed activation word
- `wgt_in` input LANES*ACT_W: lane i weights at `[i*ACT_W +: ACT_W]`
- `out_valid` output 1: result valid
- `out_ready` input 1: result consumed
- `out_bits` output LANES: bit i = 1 when lane i's clipped value is negative
- `busy` output 1: high when not IDLE
- `beta_out` output 3: beta used by the current/last tile

## Operation
- States: IDLE, ACCUM, POST, OUT.
- **IDLE → start:**
  - latch `num_words` and `alpha`; clear all accumulators; set the beat counter to 0.
  - latch beta (see adaptive beta); go to ACCUM.
  - if `num_words==0`, go straight to POST instead.
- **ACCUM:**
  - `in_ready`=1.
  - On each accepted beat, for every lane: `pc = popcount(~(wgt_i ^ act_in))` and `acc_i += 2*pc - ACT_W`.
  - Accumulation saturates at `[-2^(ACC_W-1), 2^(ACC_W-1)-1]` and never wraps.
  - After `num_words` accepted beats → POST.
- **POST:**
  - lane index k runs 0..LANES-1, one lane per cycle.
  - `s = acc_k >>> (alpha+beta)` (arithmetic, 4-bit shift amount, max 14).
  - `c = clamp(s, -CLIP, CLIP)`; `out_bits[k] = (c<0)`.
  - Adaptive sum: `sum += |c|`, saturating at `2^SUM_W-1`.
  - After lane LANES-1 → OUT.
- **OUT:**
  - `out_valid`=1; `out_bits` is stable.
  - On `out_ready` → IDLE.
- `start` outside IDLE is ignored. Changes to `num_words`, `alpha` and `beta_cfg` mid-tile have no effect.
- **Adaptive beta** is computed at start when `beta_adapt`=1:
  - `w = sum[sum_shift +: 7]`, with bits at or above SUM_W read as 0.
  - beta = 1 if `w[6]` is set, 2 if `w[5]` is the highest set bit, … 6 if `w[1]` is the highest set bit, 7 if only `w[0]` is set or `w==0`.
  - `sum` is then cleared in the same cycle, so beta always reflects the previous tile.
  - With `beta_adapt`=0: beta = `beta_cfg`; `sum` is still cleared at start.

## Timing
- Reset values: state IDLE; `in_ready`, `out_valid`, `busy` = 0; `out_bits` = 0; `beta_out` = 0; accumulators and `sum` = 0.
- Reset asserted mid-tile aborts the tile immediately; no output is produced.
- `busy` and `beta_out` update on the edge that accepts `start`.
- The first beat can be accepted the cycle after `start`.
- The last accepted beat is followed by LANES POST cycles; `out_valid` rises LANES+1 cycles after the last beat's edge.
- `out_valid` and `out_ready` both high on an edge → IDLE next cycle. A back-to-back `start` is accepted one cycle later.
- Minimum tile time: `1 + num_words + LANES + 1` cycles, with continuous `in_valid` and `out_ready`.

## Configuration
- `BNN_ADAPTIVE_BETA_EN` defined: adaptive beta, the `sum` register and the leading-one detector are compiled in, as described above.
- `BNN_ADAPTIVE_BETA_EN` undefined:
  - no `sum` register and no detector are built;
  - `beta_adapt` and `sum_shift` are ignored;
  - beta is always `beta_cfg`.
- All other behaviour is identical in both builds.

## Test plan
- `num_words=2`, all `wgt_i == act_in`, `alpha=0`, `beta_cfg=0`, adapt off → each acc=32, `out_bits=16'h0000`. `out_valid` rises LANES+1 cycles after the second beat.
- `num_words=10`, all `wgt_i = ~act_in`, `alpha=0` → acc=-160, clip -127, `out_bits=16'hFFFF`. Same stimulus with `alpha=2` → -40, `out_bits=16'hFFFF`.
- 70 beats of +16 on lane 0 → acc saturates at 1023, not wrapped. 70 beats of -16 → -1024.
- Stall `in_valid` for 3 cycles mid-tile, then hold `out_ready` low for 5 cycles → the result is unchanged. `out_valid` and `out_bits` are held, and a `start` pulse during OUT is ignored.
- Adaptive beta (macro on):
  - run tile A with every lane at -127, giving sum = 2032 (`0b111_1111_0000`);
  - start tile B with `beta_adapt=1`, `sum_shift=4` → `beta_out=1`;
  - with `sum_shift=10` → window `0b0000001` → beta=7.
- Assert `rst_n` low during ACCUM → `in_ready`, `busy` and `out_valid` go to 0 asynchronously. After release, a fresh tile produces correct results with `sum` = 0 (beta=7 when adaptive).

Source files
------------

// File: rtl/bnn_tile_engine.sv
// bnn_tile_engine: binary-NN tile datapath. Streams packed activation words
// and per-lane weight rows through LANES saturating XNOR-popcount accumulators,
// then serially scales (>>> alpha+beta), hard-tanh clips and binarises each
// lane into one packed output word.
// Optional feature macro: BNN_ADAPTIVE_BETA_EN -- builds the |c| magnitude sum
// and the leading-one detector that derives beta from the previous tile.

// One output neuron: XNOR-popcount of a beat, accumulated with saturation.
module bnn_lane #(
  parameter int ACT_W = 16,
  parameter int ACC_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [ACT_W-1:0] act,
  input  logic [ACT_W-1:0] wgt,
  output logic [ACC_W-1:0] acc
);
  localparam int PW = $clog2(ACT_W + 1);
  // wide enough to hold acc + delta without wrapping before the clamp
  localparam int SW = ((ACC_W > PW + 1) ? ACC_W : PW + 1) + 2;
  localparam logic signed [SW-1:0] MAXV = SW'((1 <<< (ACC_W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(1 <<< (ACC_W - 1)));

  logic [PW-1:0]        pc;
  logic signed [SW-1:0] delta;
  logic signed [SW-1:0] nxt;

  // popcount of matching bits, mapped to a +/-1 dot product and added to acc
  always_comb begin
    pc = '0;
    for (int b = 0; b < ACT_W; b++) pc = pc + PW'(~(act[b] ^ wgt[b]));
    delta = $signed(SW'({pc, 1'b0})) - $signed(SW'(ACT_W));
    nxt   = SW'($signed(acc)) + delta;
  end

  // accumulator: cleared at tile start, clamps instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           acc <= '0;
    else if (clr)         acc <= '0;
    else if (en) begin
      if (nxt > MAXV)      acc <= MAXV[ACC_W-1:0];
      else if (nxt < MINV) acc <= MINV[ACC_W-1:0];
      else                 acc <= nxt[ACC_W-1:0];
    end
  end
endmodule

module bnn_tile_engine #(
  parameter int LANES = 16,
  parameter int ACT_W = 16,
  parameter int ACC_W = 11,
  parameter int CLIP  = 127,
  parameter int SUM_W = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [7:0]             num_words,
  input  logic [2:0]             alpha,
  input  logic [2:0]             beta_cfg,
  input  logic                   beta_adapt,
  input  logic [3:0]             sum_shift,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACT_W-1:0]       act_in,
  input  logic [LANES*ACT_W-1:0] wgt_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_bits,
  output logic                   busy,
  output logic [2:0]             beta_out
);
  localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(LANES - 1);
  localparam logic signed [ACC_W-1:0] CLIP_P = ACC_W'(CLIP);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_POST, S_OUT} state_t;

  // per-tile configuration captured when start is accepted
  typedef struct packed {
    logic [7:0] nw;
    logic [2:0] alp;
    logic [2:0] bet;
  } tile_cfg_t;

  state_t    state_q, state_d;
  tile_cfg_t cfg_q;
  logic [7:0]    cnt_q;
  logic [KW-1:0] k_q;
  logic [2:0]    beta_sel;

  logic start_acc, beat, last_beat;
  logic [LANES-1:0][ACC_W-1:0] acc;

  logic signed [ACC_W-1:0] acc_k, s, c;
  logic [3:0]              sh;

  assign start_acc = (state_q == S_IDLE) && start;
  assign beat      = (state_q == S_ACCUM) && in_valid;
  assign last_beat = beat && (cnt_q == cfg_q.nw - 8'd1);
  assign beta_out  = cfg_q.bet;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bnn_lane #(.ACT_W(ACT_W), .ACC_W(ACC_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_acc),
      .en    (beat),
      .act   (act_in),
      .wgt   (wgt_in[i*ACT_W +: ACT_W]),
      .acc   (acc[i])
    );
  end

  // tile FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // tile FSM next state; a zero-length tile skips straight to post-processing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (num_words == 8'd0) ? S_POST : S_ACCUM;
      S_ACCUM: if (last_beat) state_d = S_POST;
      S_POST:  if (k_q == K_LAST) state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // tile FSM outputs, decoded from state only
  always_comb begin
    in_ready  = (state_q == S_ACCUM);
    out_valid = (state_q == S_OUT);
    busy      = (state_q != S_IDLE);
  end

  // lane k post-processing: scale, hard-tanh clip
  always_comb begin
    sh    = 4'(cfg_q.alp) + 4'(cfg_q.bet);
    acc_k = acc[k_q];
    s     = acc_k >>> sh;
    if (s > CLIP_P)       c = CLIP_P;
    else if (s < -CLIP_P) c = -CLIP_P;
    else                  c = s;
  end

  // config latch, beat counter, lane walker and output word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q    <= '0;
      cnt_q    <= '0;
      k_q      <= '0;
      out_bits <= '0;
    end else begin
      if (start_acc) begin
        cfg_q <= '{nw: num_words, alp: alpha, bet: beta_sel};
        cnt_q <= '0;
        k_q   <= '0;
      end
      if (beat) cnt_q <= cnt_q + 8'd1;
      if (state_q == S_POST) begin
        out_bits[k_q] <= c[ACC_W-1];
        k_q           <= k_q + KW'(1);
      end
    end
  end

`ifdef BNN_ADAPTIVE_BETA_EN
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W:0]   sum_add;
  logic [ACC_W-1:0] abs_c;
  logic [SUM_W+6:0] sum_win;
  logic [6:0]       w;
  logic [2:0]       beta_lod;

  // magnitude accumulation and leading-one beta: a larger previous-tile
  // magnitude in the window gives a smaller shift
  always_comb begin
    abs_c   = c[ACC_W-1] ? -c : c;
    sum_add = {1'b0, sum_q} + (SUM_W+1)'(abs_c);
    sum_win = {7'b0, sum_q} >> sum_shift;
    w       = sum_win[6:0];
    beta_lod = 3'd7;
    for (int b = 1; b < 7; b++) if (w[b]) beta_lod = 3'(7 - b);
    beta_sel = beta_adapt ? beta_lod : beta_cfg;
  end

  // sum of |c| over the tile; cleared as the next tile reads it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 sum_q <= '0;
    else if (start_acc)         sum_q <= '0;
    else if (state_q == S_POST) sum_q <= sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
  end
`else
  logic unused_adapt;
  assign beta_sel     = beta_cfg;
  assign unused_adapt = ^{beta_adapt, sum_shift, c};
`endif
endmodule

// File: tb/tb_bnn_tile_engine.sv
// Self-checking bench for bnn_tile_engine: table of directed tiles, hand
// sequences for stalls / back-pressure / reset / adaptive beta, and random
// tiles checked against an integer reference model.
module tb_bnn_tile_engine;
  localparam int LANES = 16;
  localparam int ACT_W = 16;
  localparam int ACC_W = 11;
  localparam int CLIP  = 127;
  localparam int SUM_W = 18;
  localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
  localparam int ACC_MIN = -(1 << (ACC_W - 1));
  localparam int SUM_MAX = (1 << SUM_W) - 1;

  logic                   clk = 0;
  logic                   rst_n = 0;
  logic                   start = 0;
  logic [7:0]             num_words = 0;
  logic [2:0]             alpha = 0, beta_cfg = 0;
  logic                   beta_adapt = 0;
  logic [3:0]             sum_shift = 0;
  logic                   in_valid = 0;
  logic                   in_ready;
  logic [ACT_W-1:0]       act_in = 0;
  logic [LANES*ACT_W-1:0] wgt_in = 0;
  logic                   out_valid;
  logic                   out_ready = 0;
  logic [LANES-1:0]       out_bits;
  logic                   busy;
  logic [2:0]             beta_out;

  bnn_tile_engine #(.LANES(LANES), .ACT_W(ACT_W), .ACC_W(ACC_W), .CLIP(CLIP), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .alpha(alpha),
    .beta_cfg(beta_cfg), .beta_adapt(beta_adapt), .sum_shift(sum_shift),
    .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in), .wgt_in(wgt_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .busy(busy), .beta_out(beta_out)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0;
  int m_sum = 0;
  logic [ACT_W-1:0]       b_act [0:255];
  logic [LANES*ACT_W-1:0] b_wgt [0:255];

  typedef struct {
    int         nw;
    int         pat;
    logic [2:0] al;
    logic [2:0] bc;
    logic [LANES-1:0] exp_bits;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
  endtask

  // beat stimulus: 0 equal, 1 inverted, 2 lane0 equal/rest inverted,
  // 3 lane0 inverted/rest equal, 4 odd lanes inverted, 5 random, 6 mostly-matching
  task automatic fill_pattern(input int pat, input int nw);
    logic [ACT_W-1:0] a, w;
    for (int j = 0; j < nw; j++) begin
      a = ACT_W'($urandom);
      b_act[j] = a;
      for (int i = 0; i < LANES; i++) begin
        case (pat)
          0: w = a;
          1: w = ~a;
          2: w = (i == 0) ? a : ~a;
          3: w = (i == 0) ? ~a : a;
          4: w = (i % 2 == 1) ? ~a : a;
          5: w = ACT_W'($urandom);
          default: w = a ^ (ACT_W'($urandom) & ACT_W'($urandom) & ACT_W'($urandom));
        endcase
        b_wgt[j][i*ACT_W +: ACT_W] = w;
      end
    end
  endtask

  // reference: integer dot products, floor division by 2^sh, clip, sign
  task automatic model_tile(input int nw, input int sh, output logic [LANES-1:0] bits);
    int acc, pc, s, c, d;
    logic [ACT_W-1:0] w;
    for (int i = 0; i < LANES; i++) begin
      acc = 0;
      for (int j = 0; j < nw; j++) begin
        w = b_wgt[j][i*ACT_W +: ACT_W];
        pc = $countones(~(w ^ b_act[j]));
        acc += 2 * pc - ACT_W;
        if (acc > ACC_MAX) acc = ACC_MAX;
        if (acc < ACC_MIN) acc = ACC_MIN;
      end
      d = 1 << sh;
      s = (acc >= 0) ? acc / d : -((-acc + d - 1) / d);
      c = (s > CLIP) ? CLIP : ((s < -CLIP) ? -CLIP : s);
      bits[i] = (c < 0);
      m_sum += (c < 0) ? -c : c;
      if (m_sum > SUM_MAX) m_sum = SUM_MAX;
    end
  endtask

  function automatic logic [2:0] model_beta(input logic ad, input logic [2:0] bc, input int sh);
`ifdef BNN_ADAPTIVE_BETA_EN
    int w;
    if (ad) begin
      w = (m_sum >> sh) % 128;
      for (int t = 6; t >= 1; t--) if (w >= (1 << t)) return 3'(7 - t);
      return 3'd7;
    end
`endif
    return bc;
  endfunction

  task automatic send_beat(input int j);
    int g;
    g = 0;
    act_in = b_act[j]; wgt_in = b_wgt[j]; in_valid = 1;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  // drives one full tile from a negedge in IDLE; ends at a negedge in IDLE
  task automatic run_tile(input int nw, input logic [2:0] al, input logic [2:0] bc,
                          input logic ad, input logic [3:0] sh, input int stall, input int hold,
                          output logic [LANES-1:0] got_bits, output logic [2:0] got_beta);
    int n, st;
    logic [LANES-1:0] held;
    check("idle_before_start", busy, 0);
    num_words = nw[7:0]; alpha = al; beta_cfg = bc; beta_adapt = ad; sum_shift = sh; start = 1;
    @(negedge clk);
    start = 0;
    num_words = 8'($urandom); alpha = 3'($urandom); beta_cfg = 3'($urandom);
    beta_adapt = 1'($urandom); sum_shift = 4'($urandom);
    check("busy_after_start", busy, 1);
    got_beta = beta_out;
    if (nw > 0) check("in_ready_accum", in_ready, 1);
    for (int j = 0; j < nw; j++) begin
      st = 0;
      if (stall == j) st = 3;
      else if (stall == -2 && $urandom_range(0, 3) == 0) st = $urandom_range(1, 2);
      in_valid = 0;
      repeat (st) @(negedge clk);
      send_beat(j);
    end
    n = 1;
    while (!out_valid && n < 400) begin @(negedge clk); n++; end
    check("out_valid_seen", out_valid, 1);
    check("out_latency", n, LANES + 1);
    held = out_bits;
    for (int k = 0; k < hold; k++) begin
      out_ready = 0;
      start = (k == 2);
      @(negedge clk);
      start = 0;
      check("hold_out_valid", out_valid, 1);
      check("hold_out_bits", out_bits, held);
    end
    got_bits = out_bits;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("idle_after_ack", busy, 0);
    check("out_valid_dropped", out_valid, 0);
  endtask

  task automatic tile_vs_model(input int nw, input logic [2:0] al, input logic [2:0] bc,
                               input logic ad, input logic [3:0] sh, input int stall, input int hold,
                               output logic [LANES-1:0] got_bits, output logic [2:0] got_beta);
    logic [LANES-1:0] eb;
    logic [2:0] ebeta;
    ebeta = model_beta(ad, bc, int'(sh));
    m_sum = 0;
    model_tile(nw, int'(al) + int'(ebeta), eb);
    run_tile(nw, al, bc, ad, sh, stall, hold, got_bits, got_beta);
    check("model_beta", got_beta, ebeta);
    check("model_bits", got_bits, eb);
  endtask

  initial begin
    logic [LANES-1:0] gb;
    logic [2:0] gbeta;
    int nw;

    tbl[0] = '{2,  0, 3'd0, 3'd0, 16'h0000};
    tbl[1] = '{10, 1, 3'd0, 3'd0, 16'hFFFF};
    tbl[2] = '{10, 1, 3'd2, 3'd0, 16'hFFFF};
    tbl[3] = '{70, 2, 3'd0, 3'd0, 16'hFFFE};
    tbl[4] = '{70, 3, 3'd0, 3'd0, 16'h0001};
    tbl[5] = '{0,  0, 3'd3, 3'd5, 16'h0000};
    tbl[6] = '{10, 1, 3'd7, 3'd7, 16'hFFFF};
    tbl[7] = '{1,  4, 3'd0, 3'd0, 16'hAAAA};
    tbl[8] = '{70, 0, 3'd7, 3'd3, 16'h0000};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_bits", out_bits, 0);
    check("rst_beta_out", beta_out, 0);
    rst_n = 1;
    @(negedge clk);

    // directed table
    for (int t = 0; t < 9; t++) begin
      fill_pattern(tbl[t].pat, tbl[t].nw);
      tile_vs_model(tbl[t].nw, tbl[t].al, tbl[t].bc, 1'b0, 4'd0, -1, 0, gb, gbeta);
      check($sformatf("tbl%0d_bits", t), gb, tbl[t].exp_bits);
      check($sformatf("tbl%0d_beta", t), gbeta, tbl[t].bc);
    end

    // 3-cycle input stall, 5-cycle output back-pressure with a stray start
    fill_pattern(5, 8);
    tile_vs_model(8, 3'd1, 3'd1, 1'b0, 4'd0, 4, 5, gb, gbeta);

    // adaptive beta: tile A leaves every lane at -127 (sum 2032)
    fill_pattern(1, 10);
    tile_vs_model(10, 3'd0, 3'd0, 1'b0, 4'd0, -1, 0, gb, gbeta);
    fill_pattern(1, 20);
    tile_vs_model(20, 3'd0, 3'd0, 1'b1, 4'd4, -1, 0, gb, gbeta);
`ifdef BNN_ADAPTIVE_BETA_EN
    check("adapt_shift4_beta", gbeta, 3'd1);
    check("adapt_shift4_bits", gb, 16'hFFFF);
`endif
    fill_pattern(0, 2);
    tile_vs_model(2, 3'd0, 3'd3, 1'b1, 4'd10, -1, 0, gb, gbeta);
`ifdef BNN_ADAPTIVE_BETA_EN
    check("adapt_shift10_beta", gbeta, 3'd7);
`else
    check("static_beta_ignores_adapt", gbeta, 3'd3);
`endif

    // random tiles
    for (int r = 0; r < 25; r++) begin
      nw = ($urandom_range(0, 5) == 0) ? $urandom_range(60, 90) : $urandom_range(0, 12);
      fill_pattern($urandom_range(5, 6), nw);
      tile_vs_model(nw, 3'($urandom), 3'($urandom), 1'($urandom), 4'($urandom),
                    ($urandom_range(0, 1) == 0) ? -1 : -2, $urandom_range(0, 4), gb, gbeta);
    end

    // reset in the middle of ACCUM
    fill_pattern(1, 10);
    num_words = 8'd10; alpha = 3'd0; beta_cfg = 3'd5; beta_adapt = 0; start = 1;
    @(negedge clk);
    start = 0;
    for (int j = 0; j < 3; j++) send_beat(j);
    in_valid = 1;
    #2 rst_n = 0;
    #1;
    check("async_rst_in_ready", in_ready, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_beta_out", beta_out, 0);
    check("async_rst_out_bits", out_bits, 0);
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    m_sum = 0;
    @(negedge clk);
    fill_pattern(1, 4);
    tile_vs_model(4, 3'd0, 3'd2, 1'b1, 4'd0, -1, 0, gb, gbeta);
`ifdef BNN_ADAPTIVE_BETA_EN
    check("post_rst_adapt_beta", gbeta, 3'd7);
`else
    check("post_rst_static_beta", gbeta, 3'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
